rr_mux_n: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes.
- Generalises the fixed 8:1 single-bit selector. Adds arbitrary width and channel count, a one-cycle output register, backpressure, and a run-time mode: external select or round-robin arbitration.
- Merges multiple producers into one stream, e.g. writeback/forwarding sources or memory-request sources in the pipelined processor.

---
 rtl/rr_mux_pkg.sv | 16 +
 rtl/rr_mux_n_pick.sv | 35 +++
 rtl/rr_mux_n.sv | 160 ++++++++++++++++
 tb/tb_rr_mux_n.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the rr_mux_n registered multiplexer.
//   mux_mode_t : run-time mode, external select or round-robin arbitration
//   next_ptr   : successor of a channel index, wrapping at the channel count
package rr_mux_pkg;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_t;

  // Wraps at the channel count, not at the power of two above it.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned channels);
    return (idx >= channels - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mux_n_pick.sv
// Combinational round-robin pick for rr_mux_n.
// Scans valid_i starting at ptr_i and wrapping modulo CHANNELS; reports the first
// requesting channel.
//   valid_i       : per-channel request vector
//   ptr_i         : highest-priority channel this cycle (always < CHANNELS)
//   grant_o       : index of the picked channel (0 when nothing is picked)
//   grant_valid_o : a channel was picked
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [SEL_W-1:0]    grant_o,
  output logic                grant_valid_o
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = ptr_i;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!grant_valid_o && valid_i[idx]) begin
        grant_o       = idx;
        grant_valid_o = 1'b1;
      end
      idx = SEL_W'(next_ptr(32'(idx), CHANNELS));
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel, W-bit registered multiplexer with valid/ready handshakes on every
// input channel and on the output. Mode 0 forwards the channel named by sel,
// mode 1 arbitrates round-robin. One output register stage, full throughput.
// Optional feature macro: RR_MUX_STARVE_EN adds per-channel starvation flags.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   in_data    : channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel data present
//   in_ready   : per-channel transfer accepted this cycle (at most one bit set)
//   mode       : 0 = select, 1 = round-robin
//   sel        : channel index in select mode (>= CHANNELS never grants)
//   out_data   : registered data of the last accepted word
//   out_chan   : channel that produced out_data
//   out_valid  : out_data holds a word
//   out_ready  : downstream accepts out_data
//   starve     : (RR_MUX_STARVE_EN only) channel waited STARVE_LIMIT cycles
module rr_mux_n
  import rr_mux_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned CHANNELS     = 8,
  parameter int unsigned SEL_W        = $clog2(CHANNELS),
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef RR_MUX_STARVE_EN
  ,
  output logic [CHANNELS-1:0]       starve
`endif
);

  logic [WIDTH-1:0] chan_data [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_split
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] rr_grant;
  logic             rr_grant_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load;
  mux_mode_t        mode_e;

  assign mode_e = mux_mode_t'(mode);

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .valid_i       (in_valid),
    .ptr_i         (ptr_q),
    .grant_o       (rr_grant),
    .grant_valid_o (rr_grant_valid)
  );

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (mode_e == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end else if (32'(sel) < CHANNELS) begin
      grant       = sel;
      grant_valid = in_valid[sel];
    end
  end

  assign load = !valid_q || out_ready;

  // Gated by reset so nothing is accepted while the register stage is cleared.
  always_comb begin
    in_ready = '0;
    if (!reset && load && grant_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (grant_valid) begin
        data_d  = chan_data[grant];
        chan_d  = grant;
        valid_d = 1'b1;
        if (mode_e == MODE_RR) begin
          ptr_d = SEL_W'(next_ptr(32'(grant), CHANNELS));
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

`ifdef RR_MUX_STARVE_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] wait_q [CHANNELS];
  logic [CntW-1:0] wait_d [CHANNELS];

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wait_d[i] = '0;
      if (in_valid[i] && !in_ready[i]) begin
        wait_d[i] = (wait_q[i] == CntMax) ? wait_q[i] : wait_q[i] + 1'b1;
      end
      starve[i] = (wait_q[i] == CntMax);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
module tb_rr_mux_n;

  localparam int C = 4;
  localparam int W = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [C*W-1:0] in_data = '0;
  logic [C-1:0]   in_valid = '0;
  logic [C-1:0]   in_ready;
  logic           mode = 1'b0;
  logic [1:0]     sel = '0;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           out_ready = 1'b1;
`ifdef RR_MUX_STARVE_EN
  logic [C-1:0]   starve;
`endif

  // 3-channel instance
  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]     in_valid3 = '0;
  logic [2:0]     in_ready3;
  logic           mode3 = 1'b0;
  logic [1:0]     sel3 = '0;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_chan3;
  logic           out_valid3;
  logic           out_ready3 = 1'b1;
`ifdef RR_MUX_STARVE_EN
  logic [2:0]     starve3;
`endif

  rr_mux_n #(.WIDTH(W), .CHANNELS(C), .STARVE_LIMIT(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RR_MUX_STARVE_EN
    ,
    .starve    (starve)
`endif
  );

  rr_mux_n #(.WIDTH(W), .CHANNELS(3), .STARVE_LIMIT(L)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (mode3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef RR_MUX_STARVE_EN
    ,
    .starve    (starve3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state for the 4-channel instance
  bit       m_valid;
  bit [7:0] m_data;
  int       m_chan;
  int       m_ptr;
  int       m_cnt [C];

  function automatic void model_reset();
    m_valid = 0;
    m_data  = 0;
    m_chan  = 0;
    m_ptr   = 0;
    for (int i = 0; i < C; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_pick(output bit gv, output int g);
    gv = 0;
    g  = 0;
    if (mode) begin
      for (int k = 0; k < C; k++) begin
        int i;
        i = (m_ptr + k) % C;
        if (!gv && in_valid[i]) begin
          gv = 1;
          g  = i;
        end
      end
    end else if (int'(sel) < C && in_valid[sel]) begin
      gv = 1;
      g  = int'(sel);
    end
  endfunction

  // Called at posedge+1 with inputs applied; checks handshake before the edge,
  // advances the model across the edge, then checks the registered outputs.
  task automatic step(input string tag);
    bit gv;
    int g;
    logic [C-1:0] er;
    model_pick(gv, g);
    er = '0;
    if ((!m_valid || out_ready) && gv) er[g] = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== er) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b want %b", tag, in_ready, er);
    end
`ifdef RR_MUX_STARVE_EN
    for (int i = 0; i < C; i++) begin
      n_tests++;
      if (starve[i] !== (m_cnt[i] == L)) begin
        n_fail++;
        $display("FAIL %s starve[%0d]: got %b want %b", tag, i, starve[i], m_cnt[i] == L);
      end
    end
`endif
    for (int i = 0; i < C; i++) begin
      if (in_valid[i] && !er[i]) m_cnt[i] = (m_cnt[i] < L) ? m_cnt[i] + 1 : L;
      else m_cnt[i] = 0;
    end
    if (!m_valid || out_ready) begin
      if (gv) begin
        m_valid = 1;
        m_data  = in_data[g*W +: W];
        m_chan  = g;
        if (mode) m_ptr = (g + 1) % C;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== m_valid || out_data !== m_data || int'(out_chan) !== m_chan) begin
      n_fail++;
      $display("FAIL %s outputs: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", tag,
               out_valid, out_data, out_chan, m_valid, m_data, m_chan);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 4'b0001;
    in_data   = 32'h0000_00C7;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b0;
    step("rst_load");
    // Word held with out_valid=1; reset between edges must clear it at once.
    reset = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%h c=%0d r=%b want all zero",
               out_valid, out_data, out_chan, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    out_ready = 1'b1;
    in_valid  = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_select();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b1111;
    in_data   = 32'h11A5_2233;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL select_ready: got %b want 0100", in_ready);
    end
    step("select");
    n_tests++;
    if (out_data !== 8'hA5 || out_chan !== 2'd2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL select_out: got d=%h c=%0d want d=a5 c=2", out_data, out_chan);
    end
    in_valid = 4'b1011;
    step("select_novalid");
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL select_drop: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_rr_fairness();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = 32'h4433_2211;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step("rr4");
      n_tests++;
      if (int'(out_chan) !== exp_seq[k] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr4_seq[%0d]: got %0d want %0d", k, out_chan, exp_seq[k]);
      end
    end
    mode = 1'b0;
    in_valid = '0;
    step("rr4_idle");
  endtask

  task automatic test_rr_wrap3();
    int exp_seq [4] = '{0, 1, 2, 0};
    do_reset();
    mode3      = 1'b1;
    in_valid3  = 3'b111;
    in_data3   = 24'h33_2211;
    out_ready3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (int'(out_chan3) !== exp_seq[k] || out_valid3 !== 1'b1
          || out_data3 !== 8'(8'h11 * (exp_seq[k] + 1))) begin
        n_fail++;
        $display("FAIL rr3_seq[%0d]: got c=%0d d=%h want c=%0d", k, out_chan3, out_data3,
                 exp_seq[k]);
      end
    end
    // sel beyond the channel count never grants
    mode3 = 1'b0;
    sel3  = 2'd3;
    #1;
    n_tests++;
    if (in_ready3 !== 3'b000) begin
      n_fail++;
      $display("FAIL rr3_sel_oob: got in_ready=%b want 000", in_ready3);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rr3_sel_oob_out: got out_valid=%b want 0", out_valid3);
    end
    in_valid3 = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b0001;
    in_data   = 32'h0000_003C;
    out_ready = 1'b1;
    step("bp_load");
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      step("bp_hold");
      n_tests++;
      if (out_data !== 8'h3C || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got d=%h v=%b r=%b want d=3c v=1 r=0000", k, out_data,
                 out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    in_data   = 32'h0000_7700;
    #1;
    n_tests++;
    if (in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 0010", in_ready);
    end
    step("bp_release");
    n_tests++;
    if (out_data !== 8'h77 || out_chan !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_nobubble: got d=%h c=%0d v=%b want d=77 c=1 v=1", out_data, out_chan,
               out_valid);
    end
    in_valid = '0;
    step("bp_idle");
  endtask

  task automatic test_skip_idle();
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hD4C3_B2A1;
    in_valid  = 4'b1111;
    step("skip_prime");   // grants ch0, pointer moves to 1
    in_valid = 4'b1001;
    step("skip_a");
    n_tests++;
    if (out_chan !== 2'd3 || out_data !== 8'hD4) begin
      n_fail++;
      $display("FAIL skip_to3: got c=%0d d=%h want c=3 d=d4", out_chan, out_data);
    end
    step("skip_b");
    n_tests++;
    if (out_chan !== 2'd0 || out_data !== 8'hA1) begin
      n_fail++;
      $display("FAIL skip_wrap0: got c=%0d d=%h want c=0 d=a1", out_chan, out_data);
    end
    in_valid = '0;
    step("skip_idle");
  endtask

`ifdef RR_MUX_STARVE_EN
  task automatic test_starve();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_valid  = 4'b1000;
    in_data   = 32'h5A00_0000;
    for (int k = 1; k <= 5; k++) begin
      step("starve_wait");
      n_tests++;
      if (starve[3] !== (k >= L)) begin
        n_fail++;
        $display("FAIL starve_rise[%0d]: got %b want %b", k, starve[3], k >= L);
      end
    end
    sel = 2'd3;
    step("starve_grant");
    n_tests++;
    if (starve[3] !== 1'b0 || out_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL starve_clear: got s=%b d=%h want s=0 d=5a", starve[3], out_data);
    end
    in_valid = '0;
    step("starve_idle");
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step("random");
    end
    in_valid = '0;
    out_ready = 1'b1;
    step("random_drain");
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h c=%0d want 0", out_valid, out_data, out_chan);
    end
    test_reset();
    test_select();
    test_rr_fairness();
    test_rr_wrap3();
    test_backpressure();
    test_skip_idle();
`ifdef RR_MUX_STARVE_EN
    test_starve();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
